// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase path: state encoding, shift-field width
// and default loop thresholds used by the loop controller and the NCO phase block top.
package nco_pkg;

  localparam int SHIFT_W = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_PULL  = 2'd2,
    ST_TRACK = 2'd3
  } state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_LOCK_THRESH = 1024;
  localparam int DEF_DWELL       = 256;
  localparam int DEF_UNLOCK_CNT  = 64;

  localparam logic [SHIFT_W-1:0] DEF_SHIFT_ACQ = 4'd2;
  localparam logic [SHIFT_W-1:0] DEF_SHIFT_TRK = 4'd6;

endpackage

// File: rtl/nco_loop_ctrl_err_mag.sv
// Combinational error magnitude with saturation of the most negative code,
// compared against the lock threshold to give a single "good" flag.
module err_mag
  import nco_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] THRESH = WIDTH'(DEF_LOCK_THRESH)
) (
  input  logic signed [WIDTH-1:0] data,
  output logic                    good
);

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] mag;

  assign raw = data;

  always_comb begin
    // -MOST_NEG does not fit, so it is clamped to the largest positive value.
    if (raw == MOST_NEG) begin
      mag = MAX_POS;
    end else if (raw[WIDTH-1]) begin
      mag = -raw;
    end else begin
      mag = raw;
    end
    good = (mag < THRESH);
  end

endmodule

// File: rtl/nco_loop_ctrl.sv
// Gear-shift and lock controller driving FEEDBACK_SHIFT of the NCO phase block.
// Optional lock-loss statistics counter enabled by defining NCO_LOOP_CTRL_STATS_EN.
module nco_loop_ctrl
  import nco_pkg::*;
#(
  parameter int                 WIDTH       = DEF_WIDTH,
  parameter logic [SHIFT_W-1:0] SHIFT_ACQ   = DEF_SHIFT_ACQ,
  parameter logic [SHIFT_W-1:0] SHIFT_TRK   = DEF_SHIFT_TRK,
  parameter int                 LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int                 DWELL       = DEF_DWELL,
  parameter int                 UNLOCK_CNT  = DEF_UNLOCK_CNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [WIDTH-1:0]  feedback_tdata,
  input  logic                     feedback_tvalid,
  output logic [SHIFT_W-1:0]       FEEDBACK_SHIFT,
  output logic                     nco_rst,
  output logic                     lock,
  output logic [1:0]               state
`ifdef NCO_LOOP_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]         lock_loss_cnt
`endif
);

  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

  logic good;

  err_mag #(
    .WIDTH  (WIDTH),
    .THRESH (WIDTH'(LOCK_THRESH))
  ) u_err_mag (
    .data (feedback_tdata),
    .good (good)
  );

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               nco_rst_q, nco_rst_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic               run_hit, bad_hit;

`ifdef NCO_LOOP_CTRL_STATS_EN
  logic [CNT_W-1:0]   loss_q, loss_d;
`endif

  assign run_hit = (run_cnt_q + CNT_W'(1)) == DWELL_C;
  assign bad_hit = (bad_cnt_q + CNT_W'(1)) == UNLOCK_C;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    nco_rst_d = 1'b0;
    run_cnt_d = run_cnt_q;
    bad_cnt_d = bad_cnt_q;
`ifdef NCO_LOOP_CTRL_STATS_EN
    loss_d    = loss_q;
`endif

    if (!enable) begin
      // Disable has priority over any dwell or unlock event in the same cycle.
      state_d   = ST_IDLE;
      shift_d   = SHIFT_ACQ;
      run_cnt_d = '0;
      bad_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ACQ;
          shift_d   = SHIFT_ACQ;
          nco_rst_d = 1'b1;
          run_cnt_d = '0;
          bad_cnt_d = '0;
        end

        ST_ACQ, ST_PULL: begin
          if (feedback_tvalid) begin
            if (!good) begin
              run_cnt_d = '0;
            end else if (!run_hit) begin
              run_cnt_d = run_cnt_q + CNT_W'(1);
            end else begin
              run_cnt_d = '0;
              if (state_q == ST_ACQ) begin
                state_d = (SHIFT_TRK == SHIFT_ACQ) ? ST_TRACK : ST_PULL;
              end else begin
                shift_d = shift_q + SHIFT_W'(1);
                if (shift_d >= SHIFT_TRK) state_d = ST_TRACK;
              end
            end
          end
        end

        ST_TRACK: begin
          if (feedback_tvalid) begin
            if (good) begin
              bad_cnt_d = '0;
            end else if (!bad_hit) begin
              bad_cnt_d = bad_cnt_q + CNT_W'(1);
            end else begin
              state_d   = ST_ACQ;
              shift_d   = SHIFT_ACQ;
              nco_rst_d = 1'b1;
              run_cnt_d = '0;
              bad_cnt_d = '0;
`ifdef NCO_LOOP_CTRL_STATS_EN
              if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
`endif
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    lock_d = (state_d == ST_TRACK);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= SHIFT_ACQ;
      nco_rst_q <= 1'b0;
      lock_q    <= 1'b0;
      run_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      nco_rst_q <= nco_rst_d;
      lock_q    <= lock_d;
      run_cnt_q <= run_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

`ifdef NCO_LOOP_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`endif

  assign FEEDBACK_SHIFT = shift_q;
  assign nco_rst        = nco_rst_q;
  assign lock           = lock_q;
  assign state          = state_q;

endmodule

// File: tb/tb_nco_loop_ctrl.sv
// Scoreboard bench for nco_loop_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor compares them. Covers lock_loss_cnt when NCO_LOOP_CTRL_STATS_EN is defined.
module tb_nco_loop_ctrl;
  import nco_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] fb = '0;
  logic               fbv = 1'b0;
  logic [3:0]         shift;
  logic               nco_rst;
  logic               lock;
  logic [1:0]         state;
  logic [15:0]        llc;

  always #5 clk = ~clk;

  nco_loop_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .feedback_tdata  (fb),
    .feedback_tvalid (fbv),
    .FEEDBACK_SHIFT  (shift),
    .nco_rst         (nco_rst),
    .lock            (lock),
    .state           (state)
`ifdef NCO_LOOP_CTRL_STATS_EN
    ,
    .lock_loss_cnt   (llc)
`endif
  );

`ifndef NCO_LOOP_CTRL_STATS_EN
  assign llc = '0;
`endif

  typedef struct {
    int          tag;
    string       name;
    logic [1:0]  st;
    logic [3:0]  sh;
    logic        nr;
    logic        lk;
    logic [15:0] llc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_llc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      if (e.tag < cyc) begin
        check({e.name, "/missed"}, 16'(cyc), 16'(e.tag));
      end else begin
        check({e.name, "/state"}, 16'(state), 16'(e.st));
        check({e.name, "/shift"}, 16'(shift), 16'(e.sh));
        check({e.name, "/nco_rst"}, 16'(nco_rst), 16'(e.nr));
        check({e.name, "/lock"}, 16'(lock), 16'(e.lk));
`ifdef NCO_LOOP_CTRL_STATS_EN
        check({e.name, "/lock_loss_cnt"}, llc, e.llc);
`endif
      end
    end
  end

  task automatic expect_next(input string nm, input logic [1:0] st, input logic [3:0] sh,
                             input logic nr, input logic lk);
    exp_t e;
    e.tag  = cyc + 1;
    e.name = nm;
    e.st   = st;
    e.sh   = sh;
    e.nr   = nr;
    e.lk   = lk;
    e.llc  = 16'(exp_llc);
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic signed [15:0] d, input logic v);
    enable = en;
    fb     = d;
    fbv    = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_chk(input int n, input logic en, input logic signed [15:0] d, input logic v,
                         input string nm, input logic [1:0] st, input logic [3:0] sh,
                         input logic nr, input logic lk);
    repeat (n - 1) step(en, d, v);
    expect_next(nm, st, sh, nr, lk);
    step(en, d, v);
  endtask

  // Dwell g=0 is ACQ->PULL, dwells 1..4 step the shift 2->6, the last one enters TRACK.
  task automatic climb(input int g0, input int g1);
    for (int g = g0; g <= g1; g++) begin
      run_chk(255, 1'b1, 16'sd0, 1'b1, $sformatf("pre_dwell%0d", g),
              (g == 0) ? ST_ACQ : ST_PULL, (g == 0) ? 4'd2 : 4'(1 + g), 1'b0, 1'b0);
      if (g == 0)
        run_chk(1, 1'b1, 16'sd0, 1'b1, "dwell0", ST_PULL, 4'd2, 1'b0, 1'b0);
      else if (g < 4)
        run_chk(1, 1'b1, 16'sd0, 1'b1, $sformatf("dwell%0d", g), ST_PULL, 4'(2 + g), 1'b0, 1'b0);
      else
        run_chk(1, 1'b1, 16'sd0, 1'b1, "dwell4", ST_TRACK, 4'd6, 1'b0, 1'b1);
    end
  endtask

  task automatic unlock(input string nm);
    run_chk(63, 1'b1, 16'sd2000, 1'b1, {nm, "_pre"}, ST_TRACK, 4'd6, 1'b0, 1'b1);
    exp_llc++;
    run_chk(1, 1'b1, 16'sd2000, 1'b1, nm, ST_ACQ, 4'd2, 1'b1, 1'b0);
  endtask

  initial begin
    int wait_cyc;
    expect_next("reset", ST_IDLE, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk(1, 1'b0, 16'sd0, 1'b1, "idle_hold", ST_IDLE, 4'd2, 1'b0, 1'b0);
    run_chk(1, 1'b1, 16'sd0, 1'b1, "start", ST_ACQ, 4'd2, 1'b1, 1'b0);

    climb(0, 4);

    run_chk(63, 1'b1, 16'sd2000, 1'b1, "trk_bad63", ST_TRACK, 4'd6, 1'b0, 1'b1);
    run_chk(1, 1'b1, 16'sd0, 1'b1, "trk_good", ST_TRACK, 4'd6, 1'b0, 1'b1);
    unlock("unlock1");

    run_chk(300, 1'b1, -16'sd32768, 1'b1, "neg_sat", ST_ACQ, 4'd2, 1'b0, 1'b0);
    climb(0, 0);

    // Invalid cycles carry a bad value that must be ignored.
    for (int i = 0; i < 511; i++) begin
      if (i == 509) expect_next("tog_pre", ST_PULL, 4'd2, 1'b0, 1'b0);
      if (i == 510) expect_next("tog_step", ST_PULL, 4'd3, 1'b0, 1'b0);
      step(1'b1, (i % 2 == 0) ? 16'sd0 : 16'sd2000, (i % 2 == 0));
    end
    climb(2, 4);
    unlock("unlock2");
    climb(0, 4);
    unlock("unlock3");

    climb(0, 2);
    repeat (100) step(1'b1, 16'sd0, 1'b1);
    enable = 1'b1;
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    exp_llc = 0;
    begin
      exp_t e;
      e.tag = cyc; e.name = "async_rst"; e.st = ST_IDLE; e.sh = 4'd2;
      e.nr = 1'b0; e.lk = 1'b0; e.llc = 16'd0;
      sb.push_back(e);
    end
    @(negedge clk);
    run_chk(1, 1'b1, 16'sd0, 1'b1, "in_reset", ST_IDLE, 4'd2, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_chk(1, 1'b0, 16'sd0, 1'b1, "post_rst_idle", ST_IDLE, 4'd2, 1'b0, 1'b0);
    run_chk(1, 1'b1, 16'sd0, 1'b1, "restart", ST_ACQ, 4'd2, 1'b1, 1'b0);

    run_chk(255, 1'b1, 16'sd0, 1'b1, "pre_drop", ST_ACQ, 4'd2, 1'b0, 1'b0);
    run_chk(1, 1'b0, 16'sd0, 1'b1, "drop_at_dwell", ST_IDLE, 4'd2, 1'b0, 1'b0);
    run_chk(1, 1'b0, 16'sd0, 1'b1, "idle_stay", ST_IDLE, 4'd2, 1'b0, 1'b0);
    run_chk(1, 1'b1, 16'sd0, 1'b1, "re_en", ST_ACQ, 4'd2, 1'b1, 1'b0);
    climb(0, 1);
    run_chk(1, 1'b0, 16'sd0, 1'b1, "drop_pull", ST_IDLE, 4'd2, 1'b0, 1'b0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) check("drain", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_loop_ctrl.md
# nco_loop_ctrl

Gear-shift and lock controller for the Costas-loop NCO phase path. It watches the loop-filter feedback stream and drives the 4-bit `FEEDBACK_SHIFT` configuration of the NCO phase block. Acquisition starts with a wide loop bandwidth (small shift) and narrows it step by step as the error settles. It reports lock, and after a loss of lock it issues a one-cycle NCO re-initialisation pulse before re-acquiring.

## Interface
Parameters:
- `WIDTH`, 16: feedback sample width (signed).
- `SHIFT_ACQ`, 4'd2: feedback shift used during acquisition.
- `SHIFT_TRK`, 4'd6: feedback shift used in tracking. Must satisfy SHIFT_TRK ≥ SHIFT_ACQ.
- `LOCK_THRESH`, 1024: error-magnitude threshold, unsigned, WIDTH bits.
- `DWELL`, 256: consecutive in-threshold samples required per gear step.
- `UNLOCK_CNT`, 64: consecutive out-of-threshold samples in TRACK that declare loss of lock.

Ports:
- `clk`  in  1: sole clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: run the controller; low forces IDLE.
- `feedback_tdata`  in  WIDTH: signed loop-filter output (same stream the NCO phase block consumes).
- `feedback_tvalid`  in  1: sample qualifier.
- `FEEDBACK_SHIFT`  out  4: shift fed to the NCO phase block.
- `nco_rst`  out  1: one-cycle pulse that resets the NCO phase block.
- `lock`  out  1: high only in TRACK.
- `state`  out  2: current state code.
- `lock_loss_cnt`  out  16: present only with `NCO_LOOP_CTRL_STATS_EN`.

## Operation
- Magnitude: mag = |feedback_tdata|. The most negative value saturates to 2^(WIDTH-1)-1.
- A sample is "good" when mag < LOCK_THRESH. Only samples with `feedback_tvalid` high are evaluated; the counters hold otherwise.
- States: IDLE=0, ACQ=1, PULL=2, TRACK=3.
- IDLE:
  - FEEDBACK_SHIFT=SHIFT_ACQ, counters cleared.
  - When enable=1: go to ACQ and assert nco_rst for one cycle.
- ACQ:
  - Good sample: run_cnt+1. Bad sample: run_cnt=0.
  - When run_cnt reaches DWELL: go to PULL and set run_cnt=0.
- PULL:
  - Same counting as ACQ.
  - At DWELL: FEEDBACK_SHIFT+1 and run_cnt=0.
  - When the increment makes FEEDBACK_SHIFT equal SHIFT_TRK: go to TRACK.
  - A bad sample only clears run_cnt. The shift is never decremented in PULL.
- TRACK:
  - Bad sample: bad_cnt+1. Good sample: bad_cnt=0.
  - When bad_cnt reaches UNLOCK_CNT: set FEEDBACK_SHIFT=SHIFT_ACQ, clear counters, pulse nco_rst and go to ACQ.
- enable low in any state: go to IDLE next cycle and clear counters. No nco_rst pulse.
- If SHIFT_TRK == SHIFT_ACQ: PULL is skipped and ACQ goes directly to TRACK at DWELL.
- Counters are 16 bits wide and cannot wrap, because each one is cleared at its terminal value.

## Timing
- All outputs are registered.
- Reset values: FEEDBACK_SHIFT=SHIFT_ACQ, nco_rst=0, lock=0, state=IDLE, lock_loss_cnt=0.
- Latency: a transition caused by the sample valid in cycle n is visible in the outputs at cycle n+1. The NCO phase block then uses the new shift from cycle n+1 onward.
- nco_rst is high for exactly one cycle, coincident with the first cycle of state=ACQ.
- lock rises in the same cycle that state becomes TRACK and falls in the same cycle that state leaves TRACK.
- Simultaneous enable falling and a DWELL/UNLOCK event: enable wins (go to IDLE, no nco_rst).
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. Operation restarts from IDLE after rst_n deasserts.

## Configuration
- Macro `NCO_LOOP_CTRL_STATS_EN`:
  - Defined: adds the `lock_loss_cnt` port. It increments on each TRACK→ACQ transition and saturates at 16'hFFFF. It is not cleared by enable, only by reset.
  - Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `nco_pkg`:
  - State encoding constants (ST_IDLE, ST_ACQ, ST_PULL, ST_TRACK).
  - Shift-field width (4).
  - Default threshold and dwell constants reused by the NCO phase block top.
- Sub-module `err_mag`: combinational signed-to-magnitude conversion with saturation plus threshold compare, producing a single `good` output.

## Test plan
- Reset release, enable=1, constant feedback 0 with tvalid every cycle (defaults):
  - nco_rst pulses at cycle 1.
  - state goes ACQ→PULL after 256 samples.
  - FEEDBACK_SHIFT steps 2→3→4→5→6, one step per 256 samples.
  - lock=1 at sample 1280.
- Feedback -32768 held in ACQ: mag saturates to 32767 (bad), run_cnt stays 0, state stays ACQ indefinitely.
- In TRACK, feed 63 samples of 2000 then 1 sample of 0, then 64 samples of 2000:
  - No unlock after the first run.
  - After the 64th sample of the second run: lock=0, nco_rst pulse, FEEDBACK_SHIFT=2, state=ACQ.
- tvalid toggling every other cycle during PULL: step timing counts valid samples only (512 cycles per step).
- enable dropped in the same cycle as the 256th good ACQ sample: state=IDLE next cycle, no shift change, no nco_rst.
- With `NCO_LOOP_CTRL_STATS_EN`: three forced unlocks give lock_loss_cnt=3; asserting rst_n low mid-PULL clears it to 0 asynchronously.
